// File: rtl/laser_pkg.sv
// Shared widths, engine/mode encodings and default colours for the laser datapath.
// Optional build macro used by datapath_laser: LASER_REDRAW_ERASE_EN.
package laser_pkg;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int C_W   = 3;
    // Signed width for Bresenham error terms; holds 2*err for a 160x120 screen.
    localparam int ERR_W = 11;

    localparam logic [C_W-1:0] LASER_COLOUR_DEF = 3'b100;
    localparam logic [C_W-1:0] BG_COLOUR_DEF    = 3'b000;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_INIT = 2'd1,
        ENG_STEP = 2'd2,
        ENG_DONE = 2'd3
    } eng_state_t;

    typedef enum logic [1:0] {
        MODE_DRAW   = 2'd0,
        MODE_ERASE  = 2'd1,
        MODE_REDRAW = 2'd2
    } mode_t;
endpackage

// File: rtl/line_engine.sv
// Bresenham line stepper: one pixel per clock from (i_x0,i_y0) to (i_x1,i_y1).
// Endpoints must stay stable from start until done; colour is captured at start.
module line_engine
    import laser_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           i_abort,
    input  logic           i_start,
    input  logic [X_W-1:0] i_x0,
    input  logic [Y_W-1:0] i_y0,
    input  logic [X_W-1:0] i_x1,
    input  logic [Y_W-1:0] i_y1,
    input  logic [C_W-1:0] i_colour,
    output logic [X_W-1:0] o_vga_x,
    output logic [Y_W-1:0] o_vga_y,
    output logic [C_W-1:0] o_colour,
    output logic           o_plot,
    output logic           o_done,
    output logic [1:0]     o_state
);
    eng_state_t              r_state, w_next;
    logic [X_W-1:0]          r_x, r_last_x;
    logic [Y_W-1:0]          r_y, r_last_y;
    logic [C_W-1:0]          r_colour, r_last_c;
    logic signed [ERR_W-1:0] r_dx, r_dy, r_err;
    logic                    r_sx_neg, r_sy_neg;

    logic signed [ERR_W-1:0] w_ddx, w_ddy, w_adx, w_ady, w_e2, w_err_nxt;
    logic                    w_at_end, w_step_x, w_step_y;

    always_comb begin
        w_ddx = $signed({{(ERR_W-X_W){1'b0}}, i_x1}) - $signed({{(ERR_W-X_W){1'b0}}, i_x0});
        w_ddy = $signed({{(ERR_W-Y_W){1'b0}}, i_y1}) - $signed({{(ERR_W-Y_W){1'b0}}, i_y0});
        w_adx = w_ddx[ERR_W-1] ? -w_ddx : w_ddx;
        w_ady = w_ddy[ERR_W-1] ? -w_ddy : w_ddy;
        w_at_end  = (r_x == i_x1) && (r_y == i_y1);
        w_e2      = r_err <<< 1;
        w_step_x  = (w_e2 >= r_dy);
        w_step_y  = (w_e2 <= r_dx);
        w_err_nxt = r_err + (w_step_x ? r_dy : 11'sd0) + (w_step_y ? r_dx : 11'sd0);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ENG_IDLE: if (i_start) w_next = ENG_INIT;
            ENG_INIT: w_next = ENG_STEP;
            ENG_STEP: if (w_at_end) w_next = ENG_DONE;
            ENG_DONE: w_next = i_start ? ENG_INIT : ENG_IDLE;
            default:  w_next = ENG_IDLE;
        endcase
        if (i_abort) w_next = ENG_IDLE;
    end

    assign o_plot   = (r_state == ENG_STEP) && !i_abort;
    assign o_done   = (r_state == ENG_DONE) && !i_abort;
    assign o_state  = r_state;
    assign o_vga_x  = o_plot ? r_x      : r_last_x;
    assign o_vga_y  = o_plot ? r_y      : r_last_y;
    assign o_colour = o_plot ? r_colour : r_last_c;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ENG_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_colour <= '0;
            r_last_x <= '0;
            r_last_y <= '0;
            r_last_c <= '0;
        end else begin
            r_state <= w_next;
            if (i_start && !i_abort && (r_state == ENG_IDLE || r_state == ENG_DONE))
                r_colour <= i_colour;
            if (r_state == ENG_INIT) begin
                r_x      <= i_x0;
                r_y      <= i_y0;
                r_dx     <= w_adx;
                r_dy     <= -w_ady;
                r_err    <= w_adx - w_ady;
                r_sx_neg <= w_ddx[ERR_W-1];
                r_sy_neg <= w_ddy[ERR_W-1];
            end else if (r_state == ENG_STEP && !w_at_end) begin
                if (w_step_x) r_x <= r_sx_neg ? r_x - X_W'(1) : r_x + X_W'(1);
                if (w_step_y) r_y <= r_sy_neg ? r_y - Y_W'(1) : r_y + Y_W'(1);
                r_err <= w_err_nxt;
            end
            // Plot bus holds the last written pixel while idle.
            if (o_plot) begin
                r_last_x <= r_x;
                r_last_y <= r_y;
                r_last_c <= r_colour;
            end
        end
    end
endmodule

// File: rtl/datapath_laser.sv
// Laser datapath: range check, cooldown counter, endpoint storage and draw/erase sequencing.
// Define LASER_REDRAW_ERASE_EN to erase a stale line before drawing to a new target.
module datapath_laser
    import laser_pkg::*;
#(
    parameter int             RANGE        = 40,
    parameter int             DELAY_CYCLES = 5000000,
    parameter int             DELAY_W      = 23,
    parameter logic [C_W-1:0] LASER_COLOUR = LASER_COLOUR_DEF,
    parameter logic [C_W-1:0] BG_COLOUR    = BG_COLOUR_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       disabled,
    input  logic       wait_draw,
    input  logic       draw_laser,
    input  logic       erase,
    input  logic       delay,
    input  logic [7:0] tower_x,
    input  logic [6:0] tower_y,
    input  logic [7:0] car_x,
    input  logic [6:0] car_y,
    input  logic       car_valid,
    output logic       car_in_range,
    output logic       draw_done,
    output logic       drawn,
    output logic       erase_done,
    output logic       delay_done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot
);
    logic [X_W-1:0]     r_p0x, r_p1x, r_n0x, r_n1x;
    logic [Y_W-1:0]     r_p0y, r_p1y, r_n0y, r_n1y;
    mode_t              r_mode, w_mode_nxt;
    logic               r_drawn, r_erase_nop, r_in_range, r_delay_done;
    logic [DELAY_W-1:0] r_cnt;

    logic               w_erase_act, w_draw_act, w_delay_act, w_idle, w_redraw;
    logic               w_start, w_take_new, w_stash, w_take_stash, w_eng_done;
    logic [C_W-1:0]     w_start_colour;
    logic [1:0]         w_state;
    logic signed [8:0]  w_ddx, w_ddy;
    logic [8:0]         w_adx, w_ady;

    assign w_erase_act = erase && !disabled;
    assign w_draw_act  = draw_laser && !disabled && !erase;
    assign w_delay_act = delay && !disabled && !erase && !draw_laser;
    assign w_idle      = (w_state == ENG_IDLE);

`ifdef LASER_REDRAW_ERASE_EN
    assign w_redraw = r_drawn && ((car_x != r_p1x) || (car_y != r_p1y));
`else
    assign w_redraw = 1'b0;
`endif

    always_comb begin
        w_start        = 1'b0;
        w_start_colour = LASER_COLOUR;
        w_mode_nxt     = r_mode;
        w_take_new     = 1'b0;
        w_stash        = 1'b0;
        w_take_stash   = 1'b0;
        if (w_idle && w_erase_act && r_drawn) begin
            w_start        = 1'b1;
            w_start_colour = BG_COLOUR;
            w_mode_nxt     = MODE_ERASE;
        end else if (w_idle && w_draw_act && w_redraw) begin
            w_start        = 1'b1;
            w_start_colour = BG_COLOUR;
            w_mode_nxt     = MODE_REDRAW;
            w_stash        = 1'b1;
        end else if (w_idle && w_draw_act) begin
            w_start    = 1'b1;
            w_mode_nxt = MODE_DRAW;
            w_take_new = 1'b1;
        end else if (w_eng_done && r_mode == MODE_REDRAW) begin
            // Old line is cleared; chain straight into the new one.
            w_start      = 1'b1;
            w_mode_nxt   = MODE_DRAW;
            w_take_stash = 1'b1;
        end
    end

    line_engine u_engine (
        .clk      (clk),
        .resetn   (resetn),
        .i_abort  (disabled),
        .i_start  (w_start),
        .i_x0     (r_p0x),
        .i_y0     (r_p0y),
        .i_x1     (r_p1x),
        .i_y1     (r_p1y),
        .i_colour (w_start_colour),
        .o_vga_x  (vga_x),
        .o_vga_y  (vga_y),
        .o_colour (colour),
        .o_plot   (plot),
        .o_done   (w_eng_done),
        .o_state  (w_state)
    );

    always_comb begin
        w_ddx = $signed({1'b0, car_x}) - $signed({1'b0, tower_x});
        w_ddy = $signed({2'b00, car_y}) - $signed({2'b00, tower_y});
        w_adx = w_ddx[8] ? -w_ddx : w_ddx;
        w_ady = w_ddy[8] ? -w_ddy : w_ddy;
    end

    assign car_in_range = r_in_range;
    assign drawn        = r_drawn;
    assign delay_done   = r_delay_done;
    assign draw_done    = w_eng_done && (r_mode == MODE_DRAW);
    assign erase_done   = (w_eng_done && (r_mode == MODE_ERASE)) || r_erase_nop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_p0x        <= '0;
            r_p0y        <= '0;
            r_p1x        <= '0;
            r_p1y        <= '0;
            r_n0x        <= '0;
            r_n0y        <= '0;
            r_n1x        <= '0;
            r_n1y        <= '0;
            r_mode       <= MODE_DRAW;
            r_drawn      <= 1'b0;
            r_erase_nop  <= 1'b0;
            r_in_range   <= 1'b0;
            r_delay_done <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_in_range <= car_valid && (w_adx <= 9'(RANGE)) && (w_ady <= 9'(RANGE));
            r_mode     <= w_mode_nxt;
            if (w_take_new) begin
                r_p0x <= tower_x;
                r_p0y <= tower_y;
                r_p1x <= car_x;
                r_p1y <= car_y;
            end
            if (w_stash) begin
                r_n0x <= tower_x;
                r_n0y <= tower_y;
                r_n1x <= car_x;
                r_n1y <= car_y;
            end
            if (w_take_stash) begin
                r_p0x <= r_n0x;
                r_p0y <= r_n0y;
                r_p1x <= r_n1x;
                r_p1y <= r_n1y;
            end
            if (disabled)
                r_drawn <= 1'b0;
            else if (w_eng_done && r_mode == MODE_DRAW)
                r_drawn <= 1'b1;
            else if (w_eng_done && r_mode == MODE_ERASE)
                r_drawn <= 1'b0;
            r_erase_nop <= w_idle && w_erase_act && !r_drawn && !r_erase_nop;
            if (!w_delay_act) begin
                r_cnt        <= '0;
                r_delay_done <= 1'b0;
            end else if (r_cnt == DELAY_W'(DELAY_CYCLES - 1)) begin
                r_cnt        <= '0;
                r_delay_done <= 1'b1;
            end else begin
                r_cnt        <= r_cnt + DELAY_W'(1);
                r_delay_done <= 1'b0;
            end
        end
    end

    logic w_unused;
    assign w_unused = wait_draw;
endmodule

// File: doc/datapath_laser.md
Name: datapath_laser

Overview:
- Datapath partner of the laser control FSM; consumes its one-hot state signals (disabled, wait_draw, draw_laser, erase, delay).
- Returns the FSM's feedback: car_in_range, draw_done, drawn, erase_done, delay_done.
- Rasterises the laser as a Bresenham line from tower to car, one pixel per clock, into the shared 160x120 VGA plot bus.
- Erases the last drawn line by replaying it in background colour.

Parameters:
- RANGE, 40, max |dx| and max |dy| (pixels, inclusive) for a car to count as in range.
- DELAY_CYCLES, 5000000, cooldown length in clocks (0.1 s at 50 MHz); must be >= 1.
- DELAY_W, 23, delay counter width.
- LASER_COLOUR, 3'b100, draw colour.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- disabled, wait_draw, draw_laser, erase, delay  in  1 each  control FSM state flags.
- tower_x  in  8  tower pixel x.
- tower_y  in  7  tower pixel y.
- car_x  in  8  target car pixel x.
- car_y  in  7  target car pixel y.
- car_valid  in  1  a car exists.
- car_in_range  out  1  registered range flag.
- draw_done  out  1  one-cycle pulse, line drawn.
- drawn  out  1  a laser line is currently on screen.
- erase_done  out  1  one-cycle pulse, line erased.
- delay_done  out  1  one-cycle pulse, cooldown expired.
- vga_x  out  8  plot x.
- vga_y  out  7  plot y.
- colour  out  3  plot colour.
- plot  out  1  write strobe.

Behaviour:
- Reset (resetn=0 at posedge):
  - All outputs 0.
  - Engine to IDLE; delay counter 0; stored endpoints 0.
  - Applies mid-line: no further plot after the reset edge.
- car_in_range: registered each cycle as car_valid & |car_x-tower_x|<=RANGE & |car_y-tower_y|<=RANGE. Differences taken at 9 bits signed, so there is 1 cycle of latency.
- Control priority if multiple flags are high: disabled > erase > draw_laser > delay.
- disabled=1:
  - Engine forced to IDLE.
  - drawn cleared; counter cleared.
  - plot=0.
- Engine states: IDLE, INIT, STEP, DONE.
- Draw sequence:
  - IDLE with draw_laser=1: latch (tower_x,tower_y) as P0 and (car_x,car_y) as P1 into the stored endpoints, then go to INIT.
  - INIT: dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+-1, err=dx+dy. err is 11-bit signed. No plot.
  - STEP: plot=1 at (x,y) with the mode colour.
    - If (x,y)==P1, go to DONE.
    - Otherwise e2=2*err.
    - If e2>=dy: err+=dy, x+=sx.
    - If e2<=dx: err+=dx, y+=sy. Both updates may occur in the same cycle.
  - DONE: draw_done=1 for exactly one cycle; drawn set to 1; back to IDLE.
  - Latency from the first draw_laser cycle to the draw_done cycle is N+2, where N=max(|dx|,|dy|)+1 is the pixel count.
  - P0==P1 gives N=1 (single pixel).
- Erase sequence:
  - IDLE with erase=1 and drawn=1: replay the stored endpoints through INIT/STEP with BG_COLOUR.
  - DONE pulses erase_done; drawn cleared.
  - If drawn=0: no plot; erase_done pulses on the next cycle.
- Delay:
  - Counter increments while delay=1.
  - delay_done=1 for one cycle when count==DELAY_CYCLES-1; counter then clears.
  - Counter clears whenever delay=0.
- Control flags drop the cycle after a done pulse. The engine is in IDLE by then and does not re-trigger.
- Inputs tower_*/car_* may change mid-line: the line uses the latched endpoints only.
- When plot=0, vga_x/vga_y/colour hold their last values.

Optional Feature:
- Macro: LASER_REDRAW_ERASE_EN.
- Defined: when draw_laser starts with drawn=1 and the new P1 differs from the stored P1:
  - Engine first replays the old line in BG_COLOUR, then draws the new line.
  - A single draw_done is issued at the end of both.
  - Latency = Nold+Nnew+4.
- Undefined: the new line is drawn over the old; stale pixels are left for the next erase.

Decomposition:
- Package laser_pkg holds:
  - screen widths (X_W=8, Y_W=7, C_W=3);
  - engine state encoding (IDLE/INIT/STEP/DONE);
  - default colours.
- Sub-module line_engine (Bresenham stepper):
  - Inputs: start, x0/y0/x1/y1, colour.
  - Outputs: vga_x/vga_y/colour/plot, done.
  - datapath_laser adds the range, delay, endpoint storage and mode muxing around it.

Test Plan:
- Range check: tower (80,60), car (120,100), valid=1 -> car_in_range=1 one cycle later. Car (121,60) -> 0. valid=0 -> 0.
- Diagonal draw: draw_laser from (10,10) to (14,13) -> plots (10,10),(11,11),(12,12),(13,12),(14,13) in colour 3'b100; draw_done exactly 7 cycles after draw_laser rises; drawn=1.
- Erase: then erase=1 -> the same 5 pixels plotted in colour 3'b000; erase_done pulse; drawn=0. Erase with drawn=0 -> no plot, erase_done on the next cycle.
- Delay: DELAY_CYCLES=4 -> delay_done exactly 4 cycles after delay asserts, single pulse.
- Reset mid-line: horizontal draw (0,0)->(50,0), resetn=0 at pixel 20 -> plot=0 from the next cycle, drawn=0. A subsequent draw starts cleanly at (0,0).
- Degenerate line: P0==P1=(5,5) -> one plot, draw_done 3 cycles after start. With LASER_REDRAW_ERASE_EN, a redraw to (6,6) -> erase (5,5) then draw (5,5),(6,6).
